// File: rtl/lcd_pkg.sv
// lcd_pkg: shared constants for the HD44780-style character LCD driver.
// Holds the command bytes, the sequencer state encoding, the byte-writer
// phase encoding, default timing, and two small helpers.
package lcd_pkg;

  localparam int DEF_T_PWRUP = 2000000;
  localparam int DEF_T_SETUP = 4;
  localparam int DEF_T_PULSE = 25;
  localparam int DEF_T_HOLD  = 2500;
  localparam int DEF_T_CLEAR = 100000;

  localparam logic [7:0] CMD_FUNC_SET = 8'h38;  // 8-bit bus, 2 lines, 5x8 font
  localparam logic [7:0] CMD_DISP_ON  = 8'h0C;  // display on, cursor off
  localparam logic [7:0] CMD_ENTRY    = 8'h06;  // auto-increment, no shift
  localparam logic [7:0] CMD_CLEAR    = 8'h01;
  localparam logic [7:0] CMD_ADDR_L1  = 8'h80;
  localparam logic [7:0] CMD_ADDR_L2  = 8'hC0;

  typedef enum logic [2:0] {
    S_PWRUP, S_INIT, S_ADDR1, S_LINE1, S_ADDR2, S_LINE2, S_IDLE
  } lcd_state_e;

  typedef enum logic [1:0] {
    W_IDLE, W_SETUP, W_PULSE, W_WAIT
  } wr_phase_e;

  function automatic logic [7:0] init_cmd(input logic [1:0] i);
    case (i)
      2'd0:    return CMD_FUNC_SET;
      2'd1:    return CMD_DISP_ON;
      2'd2:    return CMD_ENTRY;
      default: return CMD_CLEAR;
    endcase
  endfunction

  // Non-printable characters would show CGRAM/garbage glyphs; blank them.
  function automatic logic [7:0] printable(input logic [7:0] b);
    return (b < 8'h20 || b > 8'h7E) ? 8'h20 : b;
  endfunction

endpackage

// File: rtl/lcd_byte_writer.sv
// lcd_byte_writer: one LCD bus transaction (setup, enable pulse, wait).
// Ports:
//   clk, rst          clock, async active-high reset
//   start_i           request a write; accepted only when the writer is idle
//   rs_i, data_i      register select and byte for the requested write
//   done_o            one-cycle pulse on the last wait cycle
//   lcd_rs_o, lcd_e_o, lcd_data_o   LCD bus
module lcd_byte_writer
  import lcd_pkg::*;
#(
  parameter int T_SETUP = DEF_T_SETUP,
  parameter int T_PULSE = DEF_T_PULSE,
  parameter int T_HOLD  = DEF_T_HOLD,
  parameter int T_CLEAR = DEF_T_CLEAR
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  input  logic       rs_i,
  input  logic [7:0] data_i,
  output logic       done_o,
  output logic       lcd_rs_o,
  output logic       lcd_e_o,
  output logic [7:0] lcd_data_o
);

  localparam logic [31:0] SETUP_LD = 32'(T_SETUP - 1);
  localparam logic [31:0] PULSE_LD = 32'(T_PULSE - 1);
  localparam logic [31:0] HOLD_LD  = 32'(T_HOLD - 1);
  localparam logic [31:0] CLEAR_LD = 32'(T_CLEAR - 1);

  wr_phase_e   phase_q, phase_d;
  logic [31:0] cnt_q, cnt_d;
  logic        rs_q, rs_d;
  logic [7:0]  data_q, data_d;
  logic        clr_q, clr_d;
  logic        ready;

  // The writer counts as idle during its last wait cycle so the next byte
  // can start on the following cycle with no dead cycle between writes.
  assign done_o = (phase_q == W_WAIT) && (cnt_q == 32'd0);
  assign ready  = (phase_q == W_IDLE) || done_o;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q <= W_IDLE;
      cnt_q   <= 32'd0;
      rs_q    <= 1'b0;
      data_q  <= 8'h00;
      clr_q   <= 1'b0;
    end else begin
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      rs_q    <= rs_d;
      data_q  <= data_d;
      clr_q   <= clr_d;
    end
  end

  always_comb begin
    phase_d = phase_q;
    cnt_d   = cnt_q;
    rs_d    = rs_q;
    data_d  = data_q;
    clr_d   = clr_q;
    case (phase_q)
      W_SETUP: begin
        if (cnt_q == 32'd0) begin
          phase_d = W_PULSE;
          cnt_d   = PULSE_LD;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      W_PULSE: begin
        if (cnt_q == 32'd0) begin
          phase_d = W_WAIT;
          cnt_d   = clr_q ? CLEAR_LD : HOLD_LD;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      W_WAIT: begin
        if (cnt_q == 32'd0) phase_d = W_IDLE;
        else                cnt_d = cnt_q - 32'd1;
      end
      default: phase_d = W_IDLE;
    endcase
    if (start_i && ready) begin
      phase_d = W_SETUP;
      cnt_d   = SETUP_LD;
      rs_d    = rs_i;
      data_d  = data_i;
      clr_d   = !rs_i && (data_i == CMD_CLEAR);
    end
  end

  assign lcd_e_o    = (phase_q == W_PULSE);
  assign lcd_rs_o   = rs_q;
  assign lcd_data_o = data_q;

endmodule

// File: rtl/lcd_char_driver.sv
// lcd_char_driver: power-up, init and continuous 2x16 frame refresh for a
// character LCD in 8-bit mode.
// Ports:
//   clk, rst            clock, async active-high reset
//   line1, line2        row text, column 0 in bits [127:120]
//   refresh_en          1 = repeat frames back to back
//   lcd_rs, lcd_rw, lcd_e, lcd_data   LCD bus (write only)
//   init_done           high once the init commands have been written
//   frame_done          one-cycle pulse after the last byte of a frame
module lcd_char_driver
  import lcd_pkg::*;
#(
  parameter int T_PWRUP = DEF_T_PWRUP,
  parameter int T_SETUP = DEF_T_SETUP,
  parameter int T_PULSE = DEF_T_PULSE,
  parameter int T_HOLD  = DEF_T_HOLD,
  parameter int T_CLEAR = DEF_T_CLEAR
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] line1,
  input  logic [127:0] line2,
  input  logic         refresh_en,
  output logic         lcd_rs,
  output logic         lcd_rw,
  output logic         lcd_e,
  output logic [7:0]   lcd_data,
  output logic         init_done,
  output logic         frame_done
);

  localparam logic [31:0] PWRUP_LD = 32'(T_PWRUP - 1);

  lcd_state_e   state_q, state_d;
  logic [3:0]   idx_q, idx_d;
  logic [31:0]  pwr_cnt_q, pwr_cnt_d;
  logic [127:0] snap1_q, snap1_d, snap2_q, snap2_d;
  logic         init_done_q, init_done_d;
  logic         frame_done_q, frame_done_d;
  logic         snap_take;
  logic         wr_start, wr_rs, wr_done;
  logic [7:0]   wr_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_PWRUP;
      idx_q        <= 4'd0;
      pwr_cnt_q    <= PWRUP_LD;
      snap1_q      <= '0;
      snap2_q      <= '0;
      init_done_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      pwr_cnt_q    <= pwr_cnt_d;
      snap1_q      <= snap1_d;
      snap2_q      <= snap2_d;
      init_done_q  <= init_done_d;
      frame_done_q <= frame_done_d;
    end
  end

  // state_q/idx_q name the byte currently on the bus. When that byte's wait
  // ends, the next position is chosen and its write launched in the same
  // cycle, so consecutive writes abut exactly.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    pwr_cnt_d    = pwr_cnt_q;
    snap1_d      = snap1_q;
    snap2_d      = snap2_q;
    init_done_d  = init_done_q;
    frame_done_d = 1'b0;
    snap_take    = 1'b0;
    wr_start     = 1'b0;
    case (state_q)
      S_PWRUP: begin
        if (pwr_cnt_q == 32'd0) begin
          state_d  = S_INIT;
          idx_d    = 4'd0;
          wr_start = 1'b1;
        end else begin
          pwr_cnt_d = pwr_cnt_q - 32'd1;
        end
      end
      S_INIT: begin
        if (wr_done) begin
          wr_start = 1'b1;
          if (idx_q == 4'd3) begin
            state_d     = S_ADDR1;
            idx_d       = 4'd0;
            init_done_d = 1'b1;
            snap_take   = 1'b1;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      S_ADDR1: begin
        if (wr_done) begin
          state_d  = S_LINE1;
          idx_d    = 4'd0;
          wr_start = 1'b1;
        end
      end
      S_LINE1: begin
        if (wr_done) begin
          wr_start = 1'b1;
          idx_d    = idx_q + 4'd1;
          if (idx_q == 4'd15) state_d = S_ADDR2;
        end
      end
      S_ADDR2: begin
        if (wr_done) begin
          state_d  = S_LINE2;
          idx_d    = 4'd0;
          wr_start = 1'b1;
        end
      end
      S_LINE2: begin
        if (wr_done) begin
          idx_d = idx_q + 4'd1;
          if (idx_q == 4'd15) begin
            frame_done_d = 1'b1;
            if (refresh_en) begin
              state_d   = S_ADDR1;
              wr_start  = 1'b1;
              snap_take = 1'b1;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            wr_start = 1'b1;
          end
        end
      end
      S_IDLE: begin
        if (refresh_en) begin
          state_d   = S_ADDR1;
          idx_d     = 4'd0;
          wr_start  = 1'b1;
          snap_take = 1'b1;
        end
      end
      default: state_d = S_PWRUP;
    endcase

    if (snap_take) begin
      snap1_d = line1;
      snap2_d = line2;
    end

    // Byte for the position being entered; column c sits at bits
    // [8*(15-c)+7 : 8*(15-c)], and 15-c is ~c for a 4-bit index.
    wr_rs   = 1'b0;
    wr_data = 8'h00;
    case (state_d)
      S_INIT:  wr_data = init_cmd(idx_d[1:0]);
      S_ADDR1: wr_data = CMD_ADDR_L1;
      S_LINE1: begin
        wr_rs   = 1'b1;
        wr_data = printable(snap1_q[{~idx_d, 3'b000} +: 8]);
      end
      S_ADDR2: wr_data = CMD_ADDR_L2;
      S_LINE2: begin
        wr_rs   = 1'b1;
        wr_data = printable(snap2_q[{~idx_d, 3'b000} +: 8]);
      end
      default: wr_data = 8'h00;
    endcase
  end

  lcd_byte_writer #(
    .T_SETUP (T_SETUP),
    .T_PULSE (T_PULSE),
    .T_HOLD  (T_HOLD),
    .T_CLEAR (T_CLEAR)
  ) u_writer (
    .clk        (clk),
    .rst        (rst),
    .start_i    (wr_start),
    .rs_i       (wr_rs),
    .data_i     (wr_data),
    .done_o     (wr_done),
    .lcd_rs_o   (lcd_rs),
    .lcd_e_o    (lcd_e),
    .lcd_data_o (lcd_data)
  );

  assign lcd_rw     = 1'b0;
  assign init_done  = init_done_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_lcd_char_driver.sv
module tb_lcd_char_driver;

  localparam int TP = 10, TS = 2, TW = 3, TH = 5, TC = 20;
  localparam int DUR_N = TS + TW + TH;
  localparam int DUR_C = TS + TW + TC;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [127:0] line1, line2;
  logic         refresh_en;
  logic         lcd_rs, lcd_rw, lcd_e, init_done, frame_done;
  logic [7:0]   lcd_data;

  lcd_char_driver #(
    .T_PWRUP(TP), .T_SETUP(TS), .T_PULSE(TW), .T_HOLD(TH), .T_CLEAR(TC)
  ) dut (
    .clk(clk), .rst(rst), .line1(line1), .line2(line2), .refresh_en(refresh_en),
    .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_e(lcd_e), .lcd_data(lcd_data),
    .init_done(init_done), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // gap: expected rise-to-rise distance; -1 = first write after reset
  // (measured from release), 0 = not checked (follows an idle period).
  typedef struct {
    logic       rs;
    logic [7:0] d;
    int         gap;
    logic       idn;
  } exp_t;

  exp_t exp_q[$];
  int total = 0, bad = 0;
  int cyc = 0;
  int wr_count = 0, frames_seen = 0, frames_exp = 0, rel_cyc = 0;
  int pend_gap = -1, last_dur = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // ---------------- monitor ----------------
  logic       pe = 0, have_fall = 0, fs_valid = 0, pfd = 0;
  int         rise_c = 0, fall_c = 0, prev_w = 0, fs_c = 0;
  logic [8:0] prev_bus = 0;

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        pe = 0; have_fall = 0; fs_valid = 0; pfd = 0; prev_bus = 0; wr_count = 0;
      end else begin
        if ({lcd_rs, lcd_data} !== prev_bus) begin
          if (have_fall) begin
            chk("bus_change_e_low", {31'd0, lcd_e}, 32'd0);
            if (exp_q.size() > 0 && exp_q[0].gap > 0)
              chk("bus_change_time", cyc - fall_c, prev_w);
          end
          prev_bus = {lcd_rs, lcd_data};
        end
        if (lcd_e && !pe) begin
          if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_write: got rs=%0b data=0x%0h, expected no write", lcd_rs, lcd_data);
          end else begin
            e = exp_q.pop_front();
            chk("write_rs", {31'd0, lcd_rs}, {31'd0, e.rs});
            chk("write_data", {24'd0, lcd_data}, {24'd0, e.d});
            chk("init_done", {31'd0, init_done}, {31'd0, e.idn});
            chk("lcd_rw", {31'd0, lcd_rw}, 32'd0);
            if (e.gap > 0) chk("write_period", cyc - rise_c, e.gap);
            else if (e.gap < 0) chk("pwrup_first_rise", cyc - rel_cyc, TP + TS);
          end
          if (!lcd_rs && lcd_data == 8'h80) begin
            fs_c = cyc - TS;
            fs_valid = 1;
          end
          rise_c = cyc;
          wr_count++;
        end
        if (!lcd_e && pe) begin
          chk("pulse_width", cyc - rise_c, TW);
          fall_c = cyc;
          have_fall = 1;
          prev_w = (!lcd_rs && lcd_data == 8'h01) ? TC : TH;
        end
        if (frame_done) begin
          if (pfd) begin
            total++; bad++;
            $display("FAIL frame_done_width: got >1 cycle, expected 1 cycle");
          end else if (!fs_valid) begin
            total++; bad++;
            $display("FAIL frame_done_spurious: got pulse, expected none (no frame started)");
          end else begin
            chk("frame_length", cyc - fs_c, 34 * DUR_N);
            frames_seen++;
            fs_valid = 0;
          end
        end
        pfd = frame_done;
        pe  = lcd_e;
      end
    end
  end

  // ---------------- reference model / stimulus ----------------
  function automatic logic [7:0] clean(input logic [7:0] b);
    return (b < 8'h20 || b > 8'h7E) ? 8'h20 : b;
  endfunction

  task automatic push(input logic rs, input logic [7:0] d, input logic idn);
    exp_t e;
    e.rs = rs; e.d = d; e.idn = idn;
    e.gap = (pend_gap != 1) ? pend_gap : last_dur;
    pend_gap = 1;
    last_dur = (!rs && d == 8'h01) ? DUR_C : DUR_N;
    exp_q.push_back(e);
  endtask

  task automatic push_init();
    pend_gap = -1;
    push(1'b0, 8'h38, 1'b0);
    push(1'b0, 8'h0C, 1'b0);
    push(1'b0, 8'h06, 1'b0);
    push(1'b0, 8'h01, 1'b0);
  endtask

  task automatic push_frame(input logic [127:0] l1, input logic [127:0] l2);
    push(1'b0, 8'h80, 1'b1);
    for (int c = 0; c < 16; c++) push(1'b1, clean(l1[127 - 8*c -: 8]), 1'b1);
    push(1'b0, 8'hC0, 1'b1);
    for (int c = 0; c < 16; c++) push(1'b1, clean(l2[127 - 8*c -: 8]), 1'b1);
    frames_exp++;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_writes(input int n);
    int t = 0;
    while (wr_count < n && t < 5000) begin tick(1); t++; end
    if (wr_count < n) begin
      total++; bad++;
      $display("FAIL wait_writes: got %0d writes, expected %0d", wr_count, n);
    end
  endtask

  task automatic wait_frames(input int n);
    int t = 0;
    while (frames_seen < n && t < 5000) begin tick(1); t++; end
    if (frames_seen < n) begin
      total++; bad++;
      $display("FAIL wait_frames: got %0d frames, expected %0d", frames_seen, n);
    end
  endtask

  function automatic logic [127:0] rand_line();
    logic [127:0] l;
    for (int c = 0; c < 16; c++)
      l[127 - 8*c -: 8] = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255))
                                                     : 8'($urandom_range(32, 126));
    return l;
  endfunction

  initial begin
    logic [127:0] l1p, l2m, l1b, l1x;
    int base, k, ws, t;
    l1p = "PRESS * TO START";
    l2m = "MONEY: 01000    ";
    l1b = "BET MONEY (OK)  ";
    line1 = '0; line2 = '0; refresh_en = 1'b0;

    tick(3);
    chk("rst_lcd_e", {31'd0, lcd_e}, 32'd0);
    chk("rst_lcd_rs", {31'd0, lcd_rs}, 32'd0);
    chk("rst_lcd_rw", {31'd0, lcd_rw}, 32'd0);
    chk("rst_lcd_data", {24'd0, lcd_data}, 32'd0);
    chk("rst_init_done", {31'd0, init_done}, 32'd0);
    chk("rst_frame_done", {31'd0, frame_done}, 32'd0);

    line1 = l1p; line2 = l2m; refresh_en = 1'b1;
    push_init();
    push_frame(l1p, l2m);
    rel_cyc = cyc;
    rst = 1'b0;

    // mid-frame text change must not tear the frame in progress
    wait_writes(4 + 5);
    line1 = l1b;
    push_frame(l1b, l2m);

    // non-printable bytes blanked
    wait_writes(38 + 3);
    l1x = l1b;
    l1x[127:120] = 8'hE2;
    l1x[47:40]   = 8'h7F;
    line1 = l1x;
    push_frame(l1x, l2m);

    base = 72;
    for (int f = 0; f < 4; f++) begin
      k = $urandom_range(1, 30);
      wait_writes(base + k);
      l1x = rand_line();
      line1 = l1x;
      l2m = rand_line();
      line2 = l2m;
      push_frame(l1x, l2m);
      base += 34;
    end

    // drop refresh mid-frame: frame completes, then silence
    wait_writes(base + 20);
    refresh_en = 1'b0;
    wait_frames(frames_exp);
    ws = wr_count;
    tick(100);
    chk("idle_no_writes", wr_count, ws);
    chk("idle_lcd_e", {31'd0, lcd_e}, 32'd0);
    chk("idle_init_done", {31'd0, init_done}, 32'd1);

    // resume without re-init
    pend_gap = 0;
    push_frame(line1, line2);
    refresh_en = 1'b1;
    base = wr_count;
    wait_writes(base + 12);

    // reset during an enable pulse
    t = 0;
    while (!lcd_e && t < 100) begin tick(1); t++; end
    chk("pre_reset_lcd_e", {31'd0, lcd_e}, 32'd1);
    rst = 1'b1;
    #1;
    chk("abort_lcd_e", {31'd0, lcd_e}, 32'd0);
    chk("abort_lcd_rs", {31'd0, lcd_rs}, 32'd0);
    chk("abort_lcd_data", {24'd0, lcd_data}, 32'd0);
    chk("abort_init_done", {31'd0, init_done}, 32'd0);
    chk("abort_frame_done", {31'd0, frame_done}, 32'd0);
    exp_q.delete();
    frames_exp--;
    tick(3);
    line1 = l1p; line2 = "MONEY: 01000    ";
    push_init();
    push_frame(l1p, line2);
    rel_cyc = cyc;
    rst = 1'b0;
    wait_writes(4 + 5);
    refresh_en = 1'b0;
    wait_frames(frames_exp);
    tick(50);

    chk("queue_drained", exp_q.size(), 0);
    chk("frame_count", frames_seen, frames_exp);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
